// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator.
//   state_t  : FSM state encoding used by seq_gen
//   DEF_PAT  : pattern held in the shadow register after reset
//   clog2    : ceiling log2, used to size the bit index counter
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [3:0] DEF_PAT = 4'b1011;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-in, serial-out shift register, MSB first.
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset, clears the register
//   load    : load par_in (takes priority over shift)
//   shift   : shift left by one, filling with 0
//   par_in  : parallel load value
//   ser_out : current MSB of the register (a register bit, so glitch-free)
module seq_piso #(
    parameter int PAT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] par_in,
    output logic             ser_out
);

    logic [PAT_W-1:0] shreg_reg;
    logic [PAT_W-1:0] shifted;

    // Zero fill means the register is empty once the last bit has moved out,
    // so ser_out naturally drops to 0 after a frame.
    assign shifted[0] = 1'b0;
    for (genvar gi = 1; gi < PAT_W; gi++) begin : g_shift
        assign shifted[gi] = shreg_reg[gi-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_reg <= '0;
        end else if (load) begin
            shreg_reg <= par_in;
        end else if (shift) begin
            shreg_reg <= shifted;
        end
    end

    assign ser_out = shreg_reg[PAT_W-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator. Captures a PAT_W-bit pattern on start and sends
// it MSB first, one bit per clock, (repeat_cnt+1) times with gap_len idle
// cycles between frames, then pulses done for one cycle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : transmit request, honoured only in IDLE
//   abort        : return to IDLE without a done pulse
//   pattern      : pattern to send, captured on the accepted start
//   repeat_cnt   : extra frames after the first
//   gap_len      : idle cycles between frames, 0 = back-to-back
//   seq_out      : serial data, 0 when not sending
//   seq_valid    : seq_out carries a pattern bit
//   busy         : transmission in progress (until, not including, done)
//   done         : one-cycle pulse after the last bit of the last frame
module seq_gen #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 4,
    parameter logic [PAT_W-1:0] DEF_PAT = seq_pkg::DEF_PAT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap_len,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);
    import seq_pkg::*;

    localparam int              BI_W    = (clog2(PAT_W) < 1) ? 1 : clog2(PAT_W);
    localparam logic [BI_W-1:0] BIT_MAX = BI_W'(PAT_W - 1);

    state_t           state_reg, state_next;
    logic [BI_W-1:0]  bit_idx_reg, bit_idx_next;
    logic [CNT_W-1:0] frames_reg, frames_next;
    logic [CNT_W-1:0] gap_ctr_reg, gap_ctr_next;
    logic [CNT_W-1:0] gap_len_reg, gap_len_next;
    logic [PAT_W-1:0] pat_reg, pat_next;
    logic             seq_valid_reg, busy_reg, done_reg;

    logic             piso_load, piso_shift;
    logic [PAT_W-1:0] piso_par;

    // The PISO register is itself the seq_out register: it is loaded with the
    // pattern on the edge that presents the MSB, so there is no extra latency.
    seq_piso #(.PAT_W(PAT_W)) u_piso (
        .clock   (clock),
        .reset   (reset),
        .load    (piso_load),
        .shift   (piso_shift),
        .par_in  (piso_par),
        .ser_out (seq_out)
    );

    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        frames_next  = frames_reg;
        gap_ctr_next = gap_ctr_reg;
        gap_len_next = gap_len_reg;
        pat_next     = pat_reg;
        piso_load    = 1'b0;
        piso_shift   = 1'b0;
        piso_par     = pat_reg;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next   = SHIFT;
                    pat_next     = pattern;
                    gap_len_next = gap_len;
                    frames_next  = repeat_cnt;
                    bit_idx_next = BIT_MAX;
                    piso_load    = 1'b1;
                    piso_par     = pattern;
                end
            end
            SHIFT: begin
                if (bit_idx_reg != '0) begin
                    bit_idx_next = bit_idx_reg - BI_W'(1);
                    piso_shift   = 1'b1;
                end else if (frames_reg == '0) begin
                    // Shifting out the LSB leaves the register all zero.
                    state_next = DONE;
                    piso_shift = 1'b1;
                end else if (gap_len_reg == '0) begin
                    bit_idx_next = BIT_MAX;
                    frames_next  = frames_reg - CNT_W'(1);
                    piso_load    = 1'b1;
                end else begin
                    state_next   = GAP;
                    gap_ctr_next = gap_len_reg;
                    piso_shift   = 1'b1;
                end
            end
            GAP: begin
                // gap_ctr holds the number of gap cycles left including this one.
                if (gap_ctr_reg <= CNT_W'(1)) begin
                    state_next   = SHIFT;
                    gap_ctr_next = '0;
                    bit_idx_next = BIT_MAX;
                    frames_next  = frames_reg - CNT_W'(1);
                    piso_load    = 1'b1;
                end else begin
                    gap_ctr_next = gap_ctr_reg - CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE; loading zero clears seq_out
        // on the same edge.
        if (abort && state_reg != IDLE) begin
            state_next   = IDLE;
            bit_idx_next = '0;
            frames_next  = '0;
            gap_ctr_next = '0;
            piso_load    = 1'b1;
            piso_shift   = 1'b0;
            piso_par     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            bit_idx_reg   <= '0;
            frames_reg    <= '0;
            gap_ctr_reg   <= '0;
            gap_len_reg   <= '0;
            pat_reg       <= DEF_PAT;
            seq_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_idx_reg   <= bit_idx_next;
            frames_reg    <= frames_next;
            gap_ctr_reg   <= gap_ctr_next;
            gap_len_reg   <= gap_len_next;
            pat_reg       <= pat_next;
            seq_valid_reg <= (state_next == SHIFT);
            busy_reg      <= (state_next == SHIFT) || (state_next == GAP);
            done_reg      <= (state_next == DONE);
        end
    end

    assign seq_valid = seq_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen. Expected per-cycle outputs
// {seq_out, seq_valid, busy, done} are queued when stimulus is applied and
// popped/compared on the falling edge of each following cycle.
module tb_seq_gen;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [CNT_W-1:0] gap_len;
    logic             seq_out;
    logic             seq_valid;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    always #5 clock = ~clock;

    seq_gen #(
        .PAT_W   (PAT_W),
        .CNT_W   (CNT_W),
        .DEF_PAT (4'b1011)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .seq_out    (seq_out),
        .seq_valid  (seq_valid),
        .busy       (busy),
        .done       (done)
    );

    // Expectation builders: {seq_out, seq_valid, busy, done}
    function automatic void push_frame(input logic [PAT_W-1:0] pat);
        for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back({pat[i], 1'b1, 1'b1, 1'b0});
    endfunction

    function automatic void push_gap(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(4'b0010);
    endfunction

    function automatic void push_done();
        exp_q.push_back(4'b0001);
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(4'b0000);
    endfunction

    task automatic test_reset();
        logic [3:0] e, got;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; repeat_cnt = '0; gap_len = '0;
        repeat (2) @(negedge clock);
        got = {seq_out, seq_valid, busy, done};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL reset outputs: got %b required 0000", got);
        end else $display("reset outputs: %b ok", got);
        reset = 1'b0;
        push_idle(2);
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(negedge clock);
            e = exp_q.pop_front(); got = {seq_out, seq_valid, busy, done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %b required %b", k, got, e);
            end else $display("reset_idle cycle %0d: %b ok", k, got);
        end
    endtask

    task automatic test_single_frame();
        logic [3:0] e, got;
        pattern = 4'b1011; repeat_cnt = 0; gap_len = 0; start = 1'b1;
        push_frame(4'b1011); push_done(); push_idle(2);
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(negedge clock);
            e = exp_q.pop_front(); got = {seq_out, seq_valid, busy, done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL single_frame cycle %0d: got %b required %b", k, got, e);
            end else $display("single_frame cycle %0d: %b ok", k, got);
            start = 1'b0;
        end
    endtask

    task automatic test_repeat_gap();
        logic [3:0] e, got;
        pattern = 4'b1011; repeat_cnt = 1; gap_len = 2; start = 1'b1;
        push_frame(4'b1011); push_gap(2); push_frame(4'b1011); push_done(); push_idle(2);
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(negedge clock);
            e = exp_q.pop_front(); got = {seq_out, seq_valid, busy, done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL repeat_gap cycle %0d: got %b required %b", k, got, e);
            end else $display("repeat_gap cycle %0d: %b ok", k, got);
            start = 1'b0;
            // Captured settings must not follow the inputs mid-transmission.
            if (k == 2) begin
                pattern = 4'b0000; repeat_cnt = 0; gap_len = 0;
            end
        end
    endtask

    task automatic test_loopback();
        logic [3:0] e, got, hist;
        int hits;
        int hit_cyc[$];
        hist = '0; hits = 0;
        pattern = 4'b1011; repeat_cnt = 1; gap_len = 0; start = 1'b1;
        push_frame(4'b1011); push_frame(4'b1011); push_done(); push_idle(3);
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(negedge clock);
            e = exp_q.pop_front(); got = {seq_out, seq_valid, busy, done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL loopback cycle %0d: got %b required %b", k, got, e);
            end else $display("loopback cycle %0d: %b ok", k, got);
            start = 1'b0;
            // Overlapping 1011 detector fed straight from seq_out.
            hist = {hist[2:0], seq_out};
            if (hist == 4'b1011) begin
                hits++;
                hit_cyc.push_back(k);
            end
        end
        checks++;
        if (hits != 2) begin
            errors++;
            $display("FAIL loopback det count: got %0d required 2", hits);
        end else $display("loopback det count: %0d ok", hits);
        checks++;
        if (hits != 2 || hit_cyc[0] != 4 || hit_cyc[1] != 8) begin
            errors++;
            $display("FAIL loopback det cycles: got %p required 4 and 8", hit_cyc);
        end else $display("loopback det cycles: %0d %0d ok", hit_cyc[0], hit_cyc[1]);
    endtask

    task automatic test_start_busy();
        logic [3:0] e, got;
        pattern = 4'b1011; repeat_cnt = 0; gap_len = 0; start = 1'b1;
        push_frame(4'b1011); push_done(); push_idle(2);
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(negedge clock);
            e = exp_q.pop_front(); got = {seq_out, seq_valid, busy, done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL start_busy cycle %0d: got %b required %b", k, got, e);
            end else $display("start_busy cycle %0d: %b ok", k, got);
            start = (k == 2);
            if (k == 2) pattern = 4'b0000;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e, got;
        pattern = 4'b1011; repeat_cnt = 0; gap_len = 0; start = 1'b1;
        // start held through DONE is only taken in the following IDLE cycle
        push_frame(4'b1011); push_done(); push_idle(1);
        push_frame(4'b0110); push_done(); push_idle(2);
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(negedge clock);
            e = exp_q.pop_front(); got = {seq_out, seq_valid, busy, done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b required %b", k, got, e);
            end else $display("back_to_back cycle %0d: %b ok", k, got);
            start = (k == 5) || (k == 6);
            if (k == 5) pattern = 4'b0110;
        end
    endtask

    task automatic test_abort();
        logic [3:0] e, got;
        pattern = 4'b1011; repeat_cnt = 2; gap_len = 1; start = 1'b1;
        exp_q.push_back(4'b1110);
        exp_q.push_back(4'b0110);
        push_idle(6);
        push_frame(4'b1101); push_done(); push_idle(1);
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(negedge clock);
            e = exp_q.pop_front(); got = {seq_out, seq_valid, busy, done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL abort cycle %0d: got %b required %b", k, got, e);
            end else $display("abort cycle %0d: %b ok", k, got);
            // abort mid-frame, then abort+start together in IDLE, then a clean start
            abort = (k == 2) || (k == 6);
            start = (k == 6) || (k == 8);
            if (k == 8) begin
                pattern = 4'b1101; repeat_cnt = 0; gap_len = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e, got;
        pattern = 4'b1011; repeat_cnt = 3; gap_len = 2; start = 1'b1;
        push_frame(4'b1011); push_gap(1); push_idle(1);
        push_frame(4'b1011); push_done(); push_idle(1);
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(negedge clock);
            e = exp_q.pop_front(); got = {seq_out, seq_valid, busy, done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got %b required %b", k, got, e);
            end else $display("reset_mid cycle %0d: %b ok", k, got);
            reset = (k == 5);
            start = (k == 6);
            if (k == 6) begin
                pattern = seq_pkg::DEF_PAT; repeat_cnt = 0; gap_len = 0;
            end
        end
    endtask

    task automatic test_max_repeat();
        logic [3:0] e, got;
        pattern = 4'b1001; repeat_cnt = 4'hF; gap_len = 0; start = 1'b1;
        for (int f = 0; f < 16; f++) push_frame(4'b1001);
        push_done(); push_idle(1);
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(negedge clock);
            e = exp_q.pop_front(); got = {seq_out, seq_valid, busy, done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL max_repeat cycle %0d: got %b required %b", k, got, e);
            end else $display("max_repeat cycle %0d: %b ok", k, got);
            start = 1'b0;
        end
    endtask

    task automatic test_long_gap();
        logic [3:0] e, got;
        pattern = 4'b0101; repeat_cnt = 1; gap_len = 4'hF; start = 1'b1;
        push_frame(4'b0101); push_gap(15); push_frame(4'b0101); push_done(); push_idle(1);
        for (int k = 1; exp_q.size() > 0; k++) begin
            @(negedge clock);
            e = exp_q.pop_front(); got = {seq_out, seq_valid, busy, done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL long_gap cycle %0d: got %b required %b", k, got, e);
            end else $display("long_gap cycle %0d: %b ok", k, got);
            start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_repeat_gap();
        test_loopback();
        test_start_busy();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_max_repeat();
        test_long_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Serial pattern generator. It is the transmit-side counterpart of the team's serial sequence detector (seq_det).
- Captures a PAT_W-bit pattern on a start request. Shifts it out MSB-first, one bit per clock, on a single serial line.
- Optionally repeats the frame, with a programmable idle gap between frames. Signals done at the end.
- Drives seq_det's seq_in directly for loopback and self-test. Also serves as a stimulus source for other serial blocks.

Parameters:
- PAT_W, 4, pattern length in bits (min 2).
- CNT_W, 4, width of the repeat-count and gap-length fields.
- DEF_PAT, 4'b1011, pattern loaded into the shadow register at reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to transmit. Sampled only in IDLE.
- abort  in  1  synchronous abort. Returns to IDLE with no done pulse.
- pattern  in  PAT_W  pattern to send. Captured on the accepted start.
- repeat_cnt  in  CNT_W  extra frames after the first. Total frames = repeat_cnt+1.
- gap_len  in  CNT_W  idle cycles between frames. 0 means back-to-back.
- seq_out  out  1  serial data. 0 when not sending.
- seq_valid  out  1  high while seq_out carries a pattern bit.
- busy  out  1  high from the accepted start until the done cycle (exclusive).
- done  out  1  single-cycle pulse after the last bit of the last frame.

Behaviour:
- Single clock domain. All outputs are registered.
- Reset is synchronous and active-high. At the first posedge with reset=1:
  - state=IDLE.
  - seq_out=0, seq_valid=0, busy=0, done=0.
  - Shadow pattern = DEF_PAT.
  - All counters = 0.
- Reset overrides abort and start, including mid-frame.
- States (encoding in package): IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11.
- IDLE:
  - Outputs are 0.
  - On a posedge with start=1: capture pattern, repeat_cnt and gap_len. Set bit_idx=PAT_W-1 and frames_left=repeat_cnt.
  - On that same edge: seq_out<=pattern[PAT_W-1], seq_valid<=1, busy<=1. Go to SHIFT.
  - Zero latency: the first bit is visible in the cycle right after the start edge.
- SHIFT:
  - Each edge presents the next lower bit, so a frame occupies exactly PAT_W cycles.
  - On the edge leaving the LSB cycle:
    - frames_left>0 and gap_len=0: reload bit_idx, present the MSB, decrement frames_left, stay in SHIFT. No idle cycle between frames.
    - frames_left>0 and gap_len>0: go to GAP with gap_ctr=gap_len. seq_out<=0, seq_valid<=0.
    - frames_left=0: go to DONE. done<=1, busy<=0, seq_valid<=0, seq_out<=0.
- GAP:
  - seq_out=0, seq_valid=0, busy=1.
  - Lasts exactly gap_len cycles.
  - On the edge leaving the last gap cycle: present the MSB, decrement frames_left, go to SHIFT.
- DONE:
  - Lasts one cycle with done=1, then returns to IDLE.
  - A start seen during DONE is ignored. start is accepted only from IDLE, so the earliest restart is the cycle after DONE.
- start while busy:
  - Ignored, not queued.
  - Changes on pattern, repeat_cnt or gap_len during a transmission have no effect, because all three are captured.
- abort=1 in SHIFT, GAP or DONE: next edge goes to IDLE with all outputs 0. No done pulse.
- abort in IDLE is a no-op. abort and start together in IDLE: abort wins, nothing is accepted.
- Counter widths:
  - frames_left and gap_ctr are CNT_W bits, down-counting, with no wrap. repeat_cnt=2^CNT_W-1 gives 2^CNT_W frames.
  - bit_idx is clog2(PAT_W) bits.
- Frame timing: seq_out changes only on the rising edge and is stable over the whole cycle, so a seq_det sampling on the same edge sees one bit per cycle.

Decomposition:
- Package seq_pkg holds:
  - State encoding constants (IDLE/SHIFT/GAP/DONE).
  - DEF_PAT.
  - A clog2 helper function for the bit_idx width.
- Sub-module seq_piso: a PAT_W-bit parallel-in, serial-out shift register.
  - Ports: clock, reset, load, shift, par_in, ser_out.
  - seq_gen is the FSM, the counters and the output registers around it.

Test Plan:
- Single frame: reset; pattern=4'b1011, repeat_cnt=0, gap_len=0; pulse start at edge 0.
  - Required: seq_out=1,0,1,1 with seq_valid=1 in cycles 1-4.
  - done=1 in cycle 5 only; busy=1 in cycles 1-4.
- Repeat with gap: pattern=4'b1011, repeat_cnt=1, gap_len=2.
  - Required: seq_out=1011 00 1011 over cycles 1-10, with seq_valid=0 in cycles 5-6.
  - done in cycle 11.
- Loopback into seq_det (seq_out→seq_in), pattern=4'b1011, repeat_cnt=1, gap_len=0.
  - Required: stream 10111011; det_o asserts exactly twice, once per frame end.
- start ignored while busy: a second start with pattern=4'b0000 in cycle 2 of a 1011 frame.
  - Required: stream unchanged (1011); a single done.
- Abort mid-frame: abort in cycle 2 of a 1011 frame.
  - Required: cycle 3 onward seq_out=0, seq_valid=0, busy=0; done never asserts; next start works normally.
- Reset mid-frame: reset=1 during GAP with repeat_cnt=3.
  - Required: next cycle all outputs 0, state IDLE.
  - A start right after reset deasserts, with pattern=DEF_PAT, gives 1011 again.
